// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the IIC bus arbiter slice.
package iic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int RDATA_W         = 32;
    localparam int TIMEOUT_CYC_DEF = 2_000_000;

    // Falling edge of the driver busy flag from its two sampled stages.
    function automatic logic busy_fell(input logic s1, input logic s2);
        return s2 & ~s1;
    endfunction

endpackage

// File: rtl/iic_arbiter_if.sv
// Requester, response and IIC-driver signals shared by the arbiter and its environment.
interface iic_arbiter_if #(
    parameter int N_REQ = 3
);
    import iic_arb_pkg::*;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_rw;
    logic [8*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_done;
    logic               rsp_err;
    logic [RDATA_W-1:0] rsp_data;
    logic [7:0]         drv_addr;
    logic [7:0]         drv_data;
    logic               drv_write;
    logic               drv_read;
    logic               drv_busy;
    logic [RDATA_W-1:0] drv_rdata;
    logic [1:0]         grant_id;
    logic               bus_active;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, drv_busy, drv_rdata,
        output req_ready, rsp_done, rsp_err, rsp_data, drv_addr, drv_data,
               drv_write, drv_read, grant_id, bus_active
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data, drv_busy, drv_rdata,
        input  req_ready, rsp_done, rsp_err, rsp_data, drv_addr, drv_data,
               drv_write, drv_read, grant_id, bus_active
    );

endinterface

// File: rtl/iic_arbiter_rr_pick.sv
// Combinational round-robin selector: the first valid requester after last_grant wins.
module rr_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_grant,
    output logic [1:0]       winner,
    output logic             any_valid
);

    logic [1:0] idx_s;

    // Scan farthest-to-nearest so the requester right after last_grant overrides the rest.
    always_comb begin
        winner    = 2'd0;
        any_valid = 1'b0;
        idx_s     = 2'd0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx_s     = 2'((int'(last_grant) + off) % N_REQ);
            winner    = req[idx_s] ? idx_s : winner;
            any_valid = any_valid | req[idx_s];
        end
    end

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one IIC driver between N_REQ requesters, with a
// per-transaction timeout.
module iic_arbiter
    import iic_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    iic_arbiter_if.slave bus
);

    localparam int               TW         = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       LAST_RST   = 2'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

    arb_state_e         state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_q, last_d;
    logic [7:0]         drv_addr_q, drv_addr_d;
    logic [7:0]         drv_data_q, drv_data_d;
    logic               rw_q, rw_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [N_REQ-1:0]   rsp_done_q, rsp_done_d;
    logic               rsp_err_q, rsp_err_d;
    logic [RDATA_W-1:0] rsp_data_q, rsp_data_d;
    logic               drv_write_q, drv_write_d;
    logic               drv_read_q, drv_read_d;
    logic               bus_active_q, bus_active_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               busy_s1_q, busy_s2_q;

    logic [1:0]         winner_s;
    logic               any_s;
    logic               fall_s;
    logic               timeout_s;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_q),
        .winner     (winner_s),
        .any_valid  (any_s)
    );

    assign fall_s    = busy_fell(busy_s1_q, busy_s2_q);
    assign timeout_s = (timer_q == TIMER_LAST);

    // Next-state and next-output computation; strobes and pulses default low each cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        drv_addr_d  = drv_addr_q;
        drv_data_d  = drv_data_q;
        rw_d        = rw_q;
        req_ready_d = '0;
        rsp_done_d  = '0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        drv_write_d = 1'b0;
        drv_read_d  = 1'b0;
        timer_d     = timer_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (any_s) begin
                    state_d     = ISSUE;
                    grant_d     = winner_s;
                    drv_addr_d  = bus.req_addr[{winner_s, 3'b000} +: 8];
                    drv_data_d  = bus.req_data[{winner_s, 3'b000} +: 8];
                    rw_d        = bus.req_rw[winner_s];
                    req_ready_d = ONE_HOT0 << winner_s;
                    drv_write_d = ~bus.req_rw[winner_s];
                    drv_read_d  = bus.req_rw[winner_s];
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (timeout_s) begin
                    state_d    = DONE;
                    rsp_done_d = ONE_HOT0 << grant_q;
                    rsp_err_d  = 1'b1;
                end else if (bus.drv_busy) begin
                    state_d = RUN;
                    timer_d = timer_q + TW'(1);
                end else begin
                    drv_write_d = ~rw_q;
                    drv_read_d  = rw_q;
                    timer_d     = timer_q + TW'(1);
                end
            end
            RUN: begin
                if (timeout_s) begin
                    state_d    = DONE;
                    rsp_done_d = ONE_HOT0 << grant_q;
                    rsp_err_d  = 1'b1;
                end else if (fall_s) begin
                    state_d    = DONE;
                    rsp_done_d = ONE_HOT0 << grant_q;
                    rsp_data_d = rw_q ? bus.drv_rdata : rsp_data_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = grant_q;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        bus_active_d = (state_d != IDLE);
    end

    // State, registered outputs and the two-stage busy sampler.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_q       <= LAST_RST;
            drv_addr_q   <= 8'd0;
            drv_data_q   <= 8'd0;
            rw_q         <= 1'b0;
            req_ready_q  <= '0;
            rsp_done_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            drv_write_q  <= 1'b0;
            drv_read_q   <= 1'b0;
            bus_active_q <= 1'b0;
            timer_q      <= '0;
            busy_s1_q    <= 1'b0;
            busy_s2_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            drv_addr_q   <= drv_addr_d;
            drv_data_q   <= drv_data_d;
            rw_q         <= rw_d;
            req_ready_q  <= req_ready_d;
            rsp_done_q   <= rsp_done_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            drv_write_q  <= drv_write_d;
            drv_read_q   <= drv_read_d;
            bus_active_q <= bus_active_d;
            timer_q      <= timer_d;
            busy_s1_q    <= bus.drv_busy;
            busy_s2_q    <= busy_s1_q;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_done   = rsp_done_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.drv_addr   = drv_addr_q;
    assign bus.drv_data   = drv_data_q;
    assign bus.drv_write  = drv_write_q;
    assign bus.drv_read   = drv_read_q;
    assign bus.grant_id   = grant_q;
    assign bus.bus_active = bus_active_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed self-checking bench for iic_arbiter: expected responses are queued at
// request time and popped when rsp_done fires.
module tb_iic_arbiter;

    localparam int N  = 3;
    localparam int TO = 100;

    logic clk;
    logic rst;

    typedef struct {
        logic [1:0]  id;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_chk;
    int          n_fail;
    logic [31:0] model_rdata;

    iic_arbiter_if #(.N_REQ(N)) bus ();

    iic_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

    task automatic set_req(input logic [1:0] id, input logic rw, input logic [7:0] a, input logic [7:0] d);
        bus.req_valid[id]              = 1'b1;
        bus.req_rw[id]                 = rw;
        bus.req_addr[{id, 3'b000} +: 8] = a;
        bus.req_data[{id, 3'b000} +: 8] = d;
    endtask

    // Reads update the modelled rsp_data; writes and timeouts leave it alone.
    task automatic push_exp(input logic [1:0] id, input logic err, input logic rw, input logic [31:0] rdata);
        if (rw && !err) model_rdata = rdata;
        sb.push_back('{id, err, model_rdata});
    endtask

    task automatic check_done();
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_done", 32'(bus.rsp_done), 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_done", 32'(bus.rsp_done), 32'(oh(e.id)));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("rsp_data", bus.rsp_data, e.data);
        end
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            waited++;
            if (|bus.req_ready) return;
        end
        chk("ready_seen", 32'(|bus.req_ready), 32'd1);
    endtask

    task automatic txn(input logic [1:0] id, input logic rw, input logic [7:0] a, input logic [7:0] d,
                       input int pre, input int blen, input bit drop, input int exp_wait);
        int         w;
        logic [1:0] stb;
        stb = rw ? 2'b10 : 2'b01;
        wait_ready(w);
        if (exp_wait > 0) chk("grant_latency", 32'(w), 32'(exp_wait));
        chk("ready_onehot", 32'(bus.req_ready), 32'(oh(id)));
        chk("grant_id", 32'(bus.grant_id), 32'(id));
        chk("drv_addr", 32'(bus.drv_addr), 32'(a));
        if (!rw) chk("drv_data", 32'(bus.drv_data), 32'(d));
        chk("strobe_at_accept", 32'({bus.drv_read, bus.drv_write}), 32'(stb));
        if (drop) bus.req_valid[id] = 1'b0;
        step();
        chk("ready_pulse", 32'(bus.req_ready), 32'd0);
        repeat (pre) step();
        chk("strobe_held", 32'({bus.drv_read, bus.drv_write}), 32'(stb));
        bus.drv_busy = 1'b1;
        step();
        chk("strobe_drop", 32'({bus.drv_read, bus.drv_write}), 32'd0);
        repeat (blen - 1) step();
        bus.drv_busy = 1'b0;
        step();
        chk("no_early_done", 32'(bus.rsp_done), 32'd0);
        step();
        check_done();
        step();
        chk("back_to_idle", 32'({bus.rsp_done, bus.bus_active}), 32'd0);
    endtask

    initial begin
        int         w;
        logic [1:0] cid;
        n_chk         = 0;
        n_fail        = 0;
        model_rdata   = 32'd0;
        bus.req_valid = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.drv_busy  = 1'b0;
        bus.drv_rdata = 32'd0;

        rst = 1'b1;
        step();
        step();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_done", 32'(bus.rsp_done), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_drv_addr_data", 32'({bus.drv_addr, bus.drv_data}), 32'd0);
        chk("rst_strobes", 32'({bus.drv_read, bus.drv_write}), 32'd0);
        chk("rst_grant_active", 32'({bus.grant_id, bus.bus_active}), 32'd0);
        rst = 1'b0;

        // Single read from requester 0.
        bus.drv_rdata = 32'h1234_5678;
        set_req(2'd0, 1'b1, 8'h23, 8'h00);
        push_exp(2'd0, 1'b0, 1'b1, 32'h1234_5678);
        txn(2'd0, 1'b1, 8'h23, 8'h00, 0, 5, 1'b1, 1);

        // Write from requester 1; rsp_data must keep the earlier read value.
        bus.drv_rdata = 32'hDEAD_BEEF;
        set_req(2'd1, 1'b0, 8'h5C, 8'h20);
        push_exp(2'd1, 1'b0, 1'b0, 32'h0);
        txn(2'd1, 1'b0, 8'h5C, 8'h20, 3, 2, 1'b1, 1);

        // Contention after reset: all three held, expect 0,1,2,0 back to back.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_rdata = 32'd0;
        set_req(2'd0, 1'b1, 8'h10, 8'h00);
        set_req(2'd1, 1'b0, 8'h11, 8'hA1);
        set_req(2'd2, 1'b1, 8'h12, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cid           = 2'(k % 3);
            bus.drv_rdata = 32'hC0DE_0000 + 32'(k);
            push_exp(cid, 1'b0, bus.req_rw[cid], bus.drv_rdata);
            txn(cid, bus.req_rw[cid], bus.req_addr[{cid, 3'b000} +: 8], bus.req_data[{cid, 3'b000} +: 8],
                1, 2, 1'b0, 1);
        end
        bus.req_valid = '0;

        // Timeout on requester 1 with busy never rising; requester 2 withdraws meanwhile.
        set_req(2'd1, 1'b0, 8'h33, 8'h44);
        push_exp(2'd1, 1'b1, 1'b0, 32'h0);
        wait_ready(w);
        chk("to_grant_id", 32'(bus.grant_id), 32'd1);
        bus.req_valid[1] = 1'b0;
        set_req(2'd2, 1'b1, 8'h77, 8'h00);
        set_req(2'd0, 1'b1, 8'h66, 8'h00);
        repeat (49) step();
        bus.req_valid[2] = 1'b0;
        repeat (50) step();
        chk("to_not_yet", 32'(bus.rsp_done), 32'd0);
        chk("to_strobe_held", 32'(bus.drv_write), 32'd1);
        step();
        check_done();
        chk("to_strobe_low", 32'({bus.drv_read, bus.drv_write}), 32'd0);
        step();
        chk("to_idle", 32'(bus.bus_active), 32'd0);
        bus.drv_rdata = 32'h0BAD_F00D;
        push_exp(2'd0, 1'b0, 1'b1, 32'h0BAD_F00D);
        txn(2'd0, 1'b1, 8'h66, 8'h00, 0, 3, 1'b1, 1);

        // Reset while in RUN: everything clears, no completion, requester 0 next.
        set_req(2'd2, 1'b0, 8'h55, 8'h99);
        wait_ready(w);
        chk("rr_grant_id", 32'(bus.grant_id), 32'd2);
        bus.req_valid[2] = 1'b0;
        step();
        bus.drv_busy = 1'b1;
        step();
        step();
        chk("run_active", 32'(bus.bus_active), 32'd1);
        rst = 1'b1;
        step();
        chk("rr_ctrl_zero", 32'({bus.req_ready, bus.rsp_done, bus.rsp_err, bus.drv_read, bus.drv_write,
                                 bus.bus_active, bus.grant_id}), 32'd0);
        chk("rr_data_zero", bus.rsp_data, 32'd0);
        chk("rr_drv_zero", 32'({bus.drv_addr, bus.drv_data}), 32'd0);
        bus.drv_busy = 1'b0;
        rst          = 1'b0;
        model_rdata  = 32'd0;
        step();
        chk("rr_no_done", 32'(bus.rsp_done), 32'd0);
        set_req(2'd0, 1'b1, 8'h01, 8'h00);
        set_req(2'd1, 1'b1, 8'h02, 8'h00);
        set_req(2'd2, 1'b1, 8'h03, 8'h00);
        bus.drv_rdata = 32'hFACE_0001;
        push_exp(2'd0, 1'b0, 1'b1, 32'hFACE_0001);
        txn(2'd0, 1'b1, 8'h01, 8'h00, 0, 2, 1'b1, 1);
        bus.req_valid = '0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iic_arbiter.md
IIC_ARBITER -- requirements
Module: iic_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2_000_000, max cycles per transaction (20 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz; the block uses one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester transaction request, held until req_ready.
REQ-006 SHALL have port req_rw  input  N_REQ  per-requester direction: 1 = read, 0 = write.
REQ-007 SHALL have port req_addr  input  8*N_REQ  per-requester device address; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_data  input  8*N_REQ  per-requester write instruction byte.
REQ-009 SHALL have port req_ready  output  N_REQ  one-cycle accept pulse to the granted requester.
REQ-010 SHALL have port rsp_done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rsp_err  output  1  timeout flag, valid only while a rsp_done bit is high.
REQ-012 SHALL have port rsp_data  output  32  read result {H1,L1,H2,L2}, valid with rsp_done.
REQ-013 SHALL have port drv_addr  output  8  address to the IIC driver.
REQ-014 SHALL have port drv_data  output  8  instruction byte to the IIC driver.
REQ-015 SHALL have port drv_write  output  1  IIC driver write strobe.
REQ-016 SHALL have port drv_read  output  1  IIC driver read strobe.
REQ-017 SHALL have port drv_busy  input  1  IIC driver busy flag.
REQ-018 SHALL have port drv_rdata  input  32  IIC driver read bytes {H1,L1,H2,L2}.
REQ-019 SHALL have port grant_id  output  2  index of the current or last granted requester.
REQ-020 SHALL have port bus_active  output  1  high in every state except IDLE.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, RUN and DONE.
REQ-022 In IDLE with any req_valid high at edge k, SHALL pick the winner round-robin starting at last_grant+1 (mod N_REQ), enter ISSUE at k+1, and latch addr/data/rw into drv_addr/drv_data/rw_q.
REQ-023 SHALL pulse req_ready[winner] only during the first ISSUE cycle.
REQ-024 In ISSUE, SHALL hold drv_write (rw_q=0) or drv_read (rw_q=1) high until drv_busy is sampled high, then drop it on the next cycle and enter RUN.
REQ-025 SHALL never assert drv_write and drv_read together, and SHALL keep both low outside ISSUE.
REQ-026 SHALL detect busy falling edge via a 2-flop sample of drv_busy (pattern 10); in RUN, that edge moves the FSM to DONE.
REQ-027 In DONE (one cycle), SHALL pulse rsp_done[grant_id]; on read, rsp_data takes drv_rdata, on write, rsp_data holds its previous value; SHALL set last_grant=grant_id and return to IDLE.
REQ-028 SHALL run a timeout counter that clears in IDLE and counts in ISSUE and RUN; at TIMEOUT_CYC-1, SHALL drop the strobes, enter DONE with rsp_err=1, and leave rsp_data unchanged.
REQ-029 SHALL ignore req_valid changes outside IDLE; a requester that drops req_valid before grant SHALL be skipped.
REQ-030 SHALL treat req_valid still high after rsp_done as a new request; round-robin then gives other pending requesters priority.
REQ-031 SHALL add no extra latency after a single-requester grant: accept to strobe is 0 cycles, and DONE to next IDLE grant is 1 cycle.

Reset
REQ-032 On rst, SHALL reset the FSM to IDLE and clear all outputs (req_ready, rsp_done, rsp_err, rsp_data, drv_*, grant_id, bus_active) to 0.
REQ-033 On rst, SHALL set last_grant to N_REQ-1 so requester 0 wins first, and SHALL clear the busy sample and timeout counter.
REQ-034 A reset mid-transaction SHALL drop strobes the next cycle and SHALL not emit rsp_done.

Structure
REQ-035 Package iic_arb_pkg SHALL hold the FSM state encoding, RDATA_W=32 and the default TIMEOUT_CYC.
REQ-036 SHALL use one sub-module, rr_pick: a combinational round-robin selector (inputs: request vector, last grant; output: winner index, any-valid).

Verification
REQ-037 Single read: valid[0]=1, rw=1, addr=0x23, busy high 5 cycles after the strobe, drv_rdata=0x12345678 -> drv_read asserted; rsp_done[0] and rsp_data=0x12345678 two cycles after busy falls; rsp_err=0.
REQ-038 Contention: valid=3'b111 held -> grants in order 0,1,2,0; each req_ready is exactly one cycle.
REQ-039 Write: requester 1, addr=0x5C, data=0x20 -> drv_write high until busy is seen; drv_data=0x20; rsp_data unchanged.
REQ-040 Timeout: TIMEOUT_CYC=100, drv_busy held 0 -> DONE at cycle 100 with rsp_err=1 and strobe low; next request is still served.
REQ-041 Reset in RUN: rst for 1 cycle -> all outputs 0, no rsp_done; next grant goes to requester 0.
